register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised synchronous register file: two read ports, one write port, per-lane byte writes, write-to-read forwarding.
- Per-register busy scoreboard for multi-cycle producers (loads, multiply).
- Drop-in successor of the 32x32 datapath register block; single clock; no file I/O (contents held in flops).

Parameters:
DATA_W, 32, register width in bits; multiple of 8
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
rd_en  input  1  read request; samples read_reg1/read_reg2
read_reg1  input  ADDR_W  read port 1 index
read_reg2  input  ADDR_W  read port 2 index
read_data1  output  DATA_W  port 1 data, registered
read_data2  output  DATA_W  port 2 data, registered
rd_valid  output  1  read_data1/2 valid for the request of previous cycle
rd_busy1  output  1  port 1 register busy at sample time, registered with data
rd_busy2  output  1  port 2 register busy at sample time, registered with data
regWrite  input  1  write enable
byte_ops  input  1  1 = byte write: only bits [7:0] written
write_reg  input  ADDR_W  write index
write_data  input  DATA_W  write data
busy_set  input  1  mark busy_reg as busy (producer issued)
busy_reg  input  ADDR_W  index to mark busy
busy_count  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (async, on reset high): all registers = 0; busy bits = 0; read_data1/2 = 0; rd_valid = 0; rd_busy1/2 = 0; busy_count = 0. Held while reset high. Reset mid-operation discards any in-flight read (rd_valid low the cycle after release, unless rd_en).
- Write, on posedge with regWrite=1:
  - byte_ops=0: reg[write_reg] <= write_data.
  - byte_ops=1: reg[write_reg][7:0] <= write_data[7:0]; bits [DATA_W-1:8] unchanged.
  - Clears busy bit of write_reg (the write is the producer completing).
- Read, on posedge with rd_en=1:
  - read_dataN <= value of reg[read_regN] as it will be after this edge's write (write-first forwarding).
  - Forwarded value for byte_ops=1 = {old upper bits, write_data[7:0]}.
  - rd_busyN <= busy bit after this edge's updates.
  - rd_valid <= 1. Latency: 1 cycle.
- rd_en=0: read_data1/2 and rd_busy1/2 hold; rd_valid <= 0.
- Both read ports may address the same register; both return the same value.
- Scoreboard, on posedge with busy_set=1: busy[busy_reg] <= 1.
- Same edge, busy_set and regWrite to the same index: set wins (a new producer overrides the completing one); data still written.
- busy_set on an already busy register: no change; no count change.
- busy_count tracks popcount of busy bits, updated incrementally. Range 0..2**ADDR_W-ZERO_REG, never wraps.
- ZERO_REG=1, index 0:
  - writes ignored;
  - busy_set ignored;
  - reads return 0 and rd_busy=0, including forwarding.
- ZERO_REG=0: index 0 is an ordinary register.
- No x propagation: out-of-range is impossible (full decode).

Test Plan:
1. Reset: assert reset mid-cycle after writing reg5=0xDEADBEEF, then release, rd_en with read_reg1=5 -> reset is immediate without a clock edge; read_data1=0, rd_valid=1 one cycle after rd_en.
2. Byte write: write reg3=0x12345678 (byte_ops=0), then write 0x000000AB with byte_ops=1, then read -> read_data1=0x123456AB.
3. Forwarding: same edge regWrite reg7=0xCAFEF00D and rd_en read_reg1=read_reg2=7 -> next cycle read_data1=read_data2=0xCAFEF00D.
4. Zero register (ZERO_REG=1): write reg0=0xFFFFFFFF, busy_set reg0, read reg0 -> read_data1=0, rd_busy1=0, busy_count=0.
5. Scoreboard:
   - busy_set reg9 and reg10 -> busy_count=2; read reg9 -> rd_busy1=1.
   - Write reg9 -> busy_count=1.
   - Same-edge busy_set and write to reg10 -> reg10 stays busy; busy_count=1; data updated.
6. Hold: rd_en=1 read reg2=0x55, then rd_en=0 for 3 cycles while writing reg2=0x66 -> read_data1 holds 0x55; rd_valid=0 after the first cycle.

Source files
------------

// File: rtl/register_file_sb.sv
// Two-read / one-write register file with write-first forwarding, low-byte writes
// and a per-register busy scoreboard for multi-cycle producers.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              rd_valid,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              regWrite,
    input  logic              byte_ops,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_reg,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;
    logic [DATA_W-1:0] r_read_data1;
    logic [DATA_W-1:0] r_read_data2;
    logic              r_rd_valid;
    logic              r_rd_busy1;
    logic              r_rd_busy2;

    logic              w_wr_ok;
    logic              w_set_ok;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wr_val;
    logic [DEPTH-1:0]  w_busy_next;
    logic              w_inc;
    logic              w_dec;
    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;

    assign w_wr_ok  = regWrite && !((ZERO_REG != 0) && (write_reg == '0));
    assign w_set_ok = busy_set && !((ZERO_REG != 0) && (busy_reg == '0));

    // Byte writes keep the upper bits of the current contents.
    assign w_mask   = byte_ops ? DATA_W'(8'hFF) : {DATA_W{1'b1}};
    assign w_wr_val = (r_regs[write_reg] & ~w_mask) | (write_data & w_mask);

    // A new producer issued on the same edge as a completion overrides it.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok)
            w_busy_next[write_reg] = 1'b0;
        if (w_set_ok)
            w_busy_next[busy_reg] = 1'b1;
    end

    assign w_inc = w_set_ok && !r_busy[busy_reg];
    assign w_dec = w_wr_ok && r_busy[write_reg] && !(w_set_ok && (busy_reg == write_reg));

    always_comb begin
        w_fwd1 = r_regs[read_reg1];
        if (w_wr_ok && (write_reg == read_reg1))
            w_fwd1 = w_wr_val;
        if ((ZERO_REG != 0) && (read_reg1 == '0))
            w_fwd1 = '0;
    end

    always_comb begin
        w_fwd2 = r_regs[read_reg2];
        if (w_wr_ok && (write_reg == read_reg2))
            w_fwd2 = w_wr_val;
        if ((ZERO_REG != 0) && (read_reg2 == '0))
            w_fwd2 = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[write_reg] <= w_wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy <= w_busy_next;
            case ({w_inc, w_dec})
                2'b10:   r_busy_count <= r_busy_count + 1'b1;
                2'b01:   r_busy_count <= r_busy_count - 1'b1;
                default: r_busy_count <= r_busy_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_rd_busy1   <= 1'b0;
            r_rd_busy2   <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_read_data1 <= w_fwd1;
                r_read_data2 <= w_fwd2;
                r_rd_busy1   <= w_busy_next[read_reg1];
                r_rd_busy2   <= w_busy_next[read_reg2];
            end
        end
    end

    assign read_data1 = r_read_data1;
    assign read_data2 = r_read_data2;
    assign rd_valid   = r_rd_valid;
    assign rd_busy1   = r_rd_busy1;
    assign rd_busy2   = r_rd_busy2;
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb (32x32, register 0 hardwired to zero).
module tb_register_file_sb;

    logic        clk;
    logic        reset;
    logic        rd_en;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        rd_valid;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        regWrite;
    logic        byte_ops;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy_set;
    logic [4:0]  busy_reg;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_pass   = 0;

    register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .rd_valid   (rd_valid),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .regWrite   (regWrite),
        .byte_ops   (byte_ops),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy_set   (busy_set),
        .busy_reg   (busy_reg),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        rd_en      = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        regWrite   = 1'b0;
        byte_ops   = 1'b0;
        write_reg  = '0;
        write_data = '0;
        busy_set   = 1'b0;
        busy_reg   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_data1", read_data1, 32'h0);
        check("reset_valid", {31'b0, rd_valid}, 32'h0);
        check("reset_count", {26'b0, busy_count}, 32'h0);

        // Reset mid-cycle discards contents and outputs without a clock edge
        regWrite = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        tick();
        regWrite = 1'b0;
        rd_en = 1'b1; read_reg1 = 5'd5;
        tick();
        check("pre_reset_read", read_data1, 32'hDEADBEEF);
        rd_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_data", read_data1, 32'h0);
        check("async_reset_valid", {31'b0, rd_valid}, 32'h0);
        #1 reset = 1'b0;
        rd_en = 1'b1; read_reg1 = 5'd5;
        tick();
        check("post_reset_reg5", read_data1, 32'h0);
        check("post_reset_valid", {31'b0, rd_valid}, 32'h1);
        rd_en = 1'b0;

        // Byte write merges into existing upper bits
        regWrite = 1'b1; write_reg = 5'd3; write_data = 32'h12345678; byte_ops = 1'b0;
        tick();
        write_data = 32'h000000AB; byte_ops = 1'b1;
        tick();
        regWrite = 1'b0; byte_ops = 1'b0;
        rd_en = 1'b1; read_reg1 = 5'd3;
        tick();
        check("byte_write", read_data1, 32'h123456AB);
        regWrite = 1'b1; write_reg = 5'd3; write_data = 32'hFFFFFFCD; byte_ops = 1'b1;
        read_reg2 = 5'd3;
        tick();
        check("byte_fwd", read_data2, 32'h123456CD);
        regWrite = 1'b0; byte_ops = 1'b0;

        // Full-word forwarding to both ports
        regWrite = 1'b1; write_reg = 5'd7; write_data = 32'hCAFEF00D;
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        tick();
        check("fwd_port1", read_data1, 32'hCAFEF00D);
        check("fwd_port2", read_data2, 32'hCAFEF00D);
        regWrite = 1'b0;

        // Register 0 ignores writes and busy marks, including the forward path
        regWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        busy_set = 1'b1; busy_reg = 5'd0; read_reg1 = 5'd0;
        tick();
        check("zero_fwd_data", read_data1, 32'h0);
        check("zero_fwd_busy", {31'b0, rd_busy1}, 32'h0);
        check("zero_count", {26'b0, busy_count}, 32'h0);
        regWrite = 1'b0; busy_set = 1'b0;
        tick();
        check("zero_read", read_data1, 32'h0);

        // Scoreboard
        rd_en = 1'b0;
        busy_set = 1'b1; busy_reg = 5'd9;
        tick();
        busy_reg = 5'd10;
        tick();
        busy_set = 1'b0;
        check("count_two", {26'b0, busy_count}, 32'h2);
        rd_en = 1'b1; read_reg1 = 5'd9; read_reg2 = 5'd12;
        tick();
        check("busy_reg9", {31'b0, rd_busy1}, 32'h1);
        check("idle_reg12", {31'b0, rd_busy2}, 32'h0);
        rd_en = 1'b0;
        busy_set = 1'b1; busy_reg = 5'd9;
        tick();
        busy_set = 1'b0;
        check("reset_busy_no_change", {26'b0, busy_count}, 32'h2);
        regWrite = 1'b1; write_reg = 5'd9; write_data = 32'h00000099;
        tick();
        regWrite = 1'b0;
        check("write_clears", {26'b0, busy_count}, 32'h1);
        busy_set = 1'b1; busy_reg = 5'd10;
        regWrite = 1'b1; write_reg = 5'd10; write_data = 32'h00001010;
        rd_en = 1'b1; read_reg1 = 5'd10; read_reg2 = 5'd9;
        tick();
        busy_set = 1'b0; regWrite = 1'b0; rd_en = 1'b0;
        check("set_wins_count", {26'b0, busy_count}, 32'h1);
        check("set_wins_busy", {31'b0, rd_busy1}, 32'h1);
        check("set_wins_data", read_data1, 32'h00001010);
        check("reg9_not_busy", {31'b0, rd_busy2}, 32'h0);
        check("reg9_data", read_data2, 32'h00000099);
        busy_set = 1'b1; busy_reg = 5'd11;
        regWrite = 1'b1; write_reg = 5'd10; write_data = 32'h0;
        tick();
        busy_set = 1'b0; regWrite = 1'b0;
        check("set_and_clear_other", {26'b0, busy_count}, 32'h1);

        // Outputs hold while rd_en is low
        regWrite = 1'b1; write_reg = 5'd2; write_data = 32'h00000055;
        tick();
        regWrite = 1'b0;
        rd_en = 1'b1; read_reg1 = 5'd2;
        tick();
        check("hold_initial", read_data1, 32'h00000055);
        check("hold_valid_hi", {31'b0, rd_valid}, 32'h1);
        rd_en = 1'b0;
        regWrite = 1'b1; write_data = 32'h00000066;
        tick();
        check("hold_c1_data", read_data1, 32'h00000055);
        check("hold_c1_valid", {31'b0, rd_valid}, 32'h0);
        tick();
        tick();
        check("hold_c3_data", read_data1, 32'h00000055);
        check("hold_c3_valid", {31'b0, rd_valid}, 32'h0);
        regWrite = 1'b0;
        rd_en = 1'b1;
        tick();
        check("after_hold", read_data1, 32'h00000066);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
